udp_tx_arb: RTL and testbench
=============================

# udp_tx_arb

Frame-level arbiter that shares the single UDP transmit path among `S_COUNT` requesters. Each requester presents a reduced UDP header (destination IP, ports, length, checksum) plus an 8-bit AXI-stream payload. The block grants one requester at a time, registers its header, and forwards its payload until `tlast`. It sits directly in front of the UDP block's UDP frame input; the remaining IP/Ethernet header fields are tied off at the integration level.

## Interface
- `S_COUNT`, 4, number of requesters, legal range 1..16.
- `GW`, derived: `$clog2(S_COUNT)`, minimum 1; width of the grant index.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_udp_hdr_valid`  in  S_COUNT  per-requester header valid.
- `s_udp_hdr_ready`  out  S_COUNT  per-requester header accept; one-cycle pulse.
- `s_udp_ip_dest_ip`  in  32*S_COUNT  packed; requester i occupies bits [32i+31:32i].
- `s_udp_source_port`, `s_udp_dest_port`, `s_udp_length`, `s_udp_checksum`  in  16*S_COUNT each  packed header fields.
- `s_udp_payload_axis_tdata`  in  8*S_COUNT  packed payload data.
- `s_udp_payload_axis_tvalid`, `s_udp_payload_axis_tlast`, `s_udp_payload_axis_tuser`  in  S_COUNT each  payload sideband.
- `s_udp_payload_axis_tready`  out  S_COUNT  payload ready.
- `m_udp_hdr_valid`  out  1; `m_udp_hdr_ready`  in  1  output header handshake.
- `m_udp_ip_dest_ip`  out  32; `m_udp_source_port`, `m_udp_dest_port`, `m_udp_length`, `m_udp_checksum`  out  16 each  registered header.
- `m_udp_payload_axis_tdata`  out  8; `m_udp_payload_axis_tvalid`, `m_udp_payload_axis_tlast`, `m_udp_payload_axis_tuser`  out  1 each; `m_udp_payload_axis_tready`  in  1.
- `grant`  out  GW  index of the current owner.
- `grant_valid`  out  1  high while a frame is owned.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, HDR and PAYLOAD.
- **IDLE**
  - If any `s_udp_hdr_valid` is set, select winner `w` per the arbitration rule (see Configuration).
  - Latch `w`'s header fields into the output registers.
  - Pulse `s_udp_hdr_ready[w]` for this cycle only.
  - Set `grant = w` and `grant_valid = 1`, then go to HDR.
- **HDR**
  - Hold `m_udp_hdr_valid = 1` with stable fields until `m_udp_hdr_ready` is sampled high, then go to PAYLOAD.
  - No payload moves in this state.
- **PAYLOAD**
  - Combinational pass-through of the granted lane: `m_*_tdata/tvalid/tlast/tuser` come from lane `grant`.
  - `s_udp_payload_axis_tready[grant] = m_udp_payload_axis_tready`.
  - All other lanes' `tready` are 0.
  - On a beat with `tvalid & tready & tlast`:
    - go to IDLE and drop `grant_valid`;
    - update the priority pointer to `grant+1`, wrapping to 0 after `S_COUNT-1`.
- **Non-granted requesters** see `s_udp_hdr_ready = 0` and `tready = 0`; their inputs are held by the source, never dropped.
- **Requester changes**: a requester deasserting `hdr_valid` before it is granted is legal and is simply not considered.
- **`tuser` handling**: passed through unmodified, with no frame-level action. Error marking is the downstream block's job.

## Timing
- **Reset values**
  - State IDLE, priority pointer 0.
  - `m_udp_hdr_valid` 0, header registers 0.
  - `grant` 0, `grant_valid` 0, `busy` 0.
  - All `s_*_ready` 0; `m_udp_payload_axis_tvalid` 0 (forced low outside PAYLOAD).
- **Header latency**: `s_udp_hdr_valid` seen in IDLE (cycle N) gives `m_udp_hdr_valid` high at N+1.
- **Payload start**: the first payload beat can transfer in the cycle after the `m_udp_hdr_ready` handshake.
- **Payload latency**: zero cycles, pass-through with no buffering.
- **Frame-to-frame gap**: the cycle after `tlast` is IDLE, so minimum gap is 1 cycle. The next grant is decided in that IDLE cycle.
- **Single-beat frame**: tlast on the first payload beat is legal; the block returns to IDLE normally.
- **Reset mid-frame**: asynchronous return to reset values. The partial frame is truncated with no `tlast` emitted; the downstream block flags early termination.
- **`S_COUNT = 1`**: `grant` is always 0 and the arbitration rule is trivial.

## Configuration
- Macro `UDP_TX_ARB_ROUND_ROBIN_EN`.
- **Defined**: round-robin arbitration.
  - Search starts at the priority pointer and takes the first index with `hdr_valid` set, wrapping modulo `S_COUNT`.
  - The pointer updates to `grant+1` at end of frame.
- **Undefined**: fixed priority, lowest index wins. The pointer register is not built.

## Test plan
- Single requester 0, header {dest_ip 0x0A000001, sport 1234, dport 5678, len 12}, 4-byte payload AA BB CC DD with tlast on DD → one `s_udp_hdr_ready[0]` pulse. Matching `m_udp_*` header appears one cycle later. The 4 payload bytes appear unchanged with tlast on DD; `busy` returns to 0.
- `m_udp_hdr_ready` held low for 5 cycles → header fields and `m_udp_hdr_valid` stay stable. No payload `tready` reaches the source until the handshake completes.
- With the macro defined, lanes 0, 1 and 3 request continuously with 2-byte frames → grant order 0, 1, 3, 0, 1, 3. Lane 2 is never granted.
- Without the macro, same stimulus → lane 0 wins every frame; lanes 1 and 3 see `hdr_ready = 0` throughout.
- Payload backpressure: `m_udp_payload_axis_tready` toggles 1010 while lane 2 streams → `s_udp_payload_axis_tready[2]` mirrors it exactly. Other lanes' `tready` stay 0, and a `tuser = 1` beat passes through unchanged.
- `rst` asserted asynchronously mid-payload of lane 1 (after byte 2 of 6) → all outputs take reset values immediately. After release, a pending lane 0 request is granted from IDLE.

Source files
------------

// File: rtl/udp_tx_arb_if.sv
// -----------------------------------------------------------------------------
// udp_tx_arb_if
// One or more UDP frame lanes: a reduced UDP header handshake plus an 8-bit
// AXI-stream payload. Lane i of every packed field occupies slice i of that
// field, for example ip_dest_ip[32*i +: 32] or tdata[8*i +: 8].
//
// Parameter
//   N            number of lanes in the bundle
//
// Signals (direction seen from the master/source side)
//   hdr_valid    out  N      header valid, one bit per lane
//   hdr_ready    in   N      header accept
//   ip_dest_ip   out  32*N   destination IP
//   source_port  out  16*N   UDP source port
//   dest_port    out  16*N   UDP destination port
//   length       out  16*N   UDP length
//   checksum     out  16*N   UDP checksum
//   tdata        out  8*N    payload byte
//   tvalid       out  N      payload valid
//   tlast        out  N      last payload byte of the frame
//   tuser        out  N      payload user/error bit, carried transparently
//   tready       in   N      payload ready
//
// Handshake rule, for both the header and the payload: a transfer happens on
// a rising clock edge where valid and ready are both high. The source keeps
// valid and its data stable until that edge, and may not make valid depend
// on ready. Ready may depend on valid.
// -----------------------------------------------------------------------------
interface udp_tx_arb_if #(
  parameter int N = 1
);
  logic [N-1:0]    hdr_valid;
  logic [N-1:0]    hdr_ready;
  logic [32*N-1:0] ip_dest_ip;
  logic [16*N-1:0] source_port;
  logic [16*N-1:0] dest_port;
  logic [16*N-1:0] length;
  logic [16*N-1:0] checksum;
  logic [8*N-1:0]  tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tuser;
  logic [N-1:0]    tready;

  modport master (
    output hdr_valid, ip_dest_ip, source_port, dest_port, length, checksum,
    output tdata, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, ip_dest_ip, source_port, dest_port, length, checksum,
    input  tdata, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

// File: rtl/udp_tx_arb.sv
// -----------------------------------------------------------------------------
// udp_tx_arb
// Frame-level arbiter that shares one UDP transmit path among S_COUNT
// requesters. In IDLE one requester is picked and its header is registered.
// HDR presents that header downstream. PAYLOAD passes the granted lane's
// payload straight through, with no buffering, until tlast.
//
// Build option: define UDP_TX_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// The search starts at a priority pointer, and the pointer moves to grant+1
// at end of frame. Without the macro, arbitration is fixed priority (lowest
// index wins) and no pointer register is built.
//
// Ports
//   clk          in   1           rising-edge clock
//   rst          in   1           asynchronous active-high reset
//   s_udp        slave  modport   S_COUNT requester lanes (header + payload)
//   m_udp        master modport   single output lane (header + payload)
//   grant        out  GW          index of the current owner
//   grant_valid  out  1           high while a frame is owned
//   busy         out  1           high in any state other than IDLE
//   state_o      out  2           FSM state, for observation
// -----------------------------------------------------------------------------
module udp_tx_arb #(
  parameter  int S_COUNT = 4,
  localparam int GW      = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  udp_tx_arb_if.slave         s_udp,
  udp_tx_arb_if.master        m_udp,
  output logic [GW-1:0]       grant,
  output logic                grant_valid,
  output logic                busy,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [31:0]   ip_q, ip_d;
  logic [15:0]   sport_q, sport_d;
  logic [15:0]   dport_q, dport_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   csum_q, csum_d;

  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic [S_COUNT-1:0] hdr_ready_s;
  logic [S_COUNT-1:0] tready_s;
  logic [7:0]         m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tuser;
  logic               beat_last;

`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW:0]   idx_ext;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection among the requesters currently raising hdr_valid.
  // ---------------------------------------------------------------------------
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
  // Scan S_COUNT positions starting at the pointer. One spare bit lets
  // ptr+i overflow past S_COUNT-1 before it is folded back, so a lane count
  // that is not a power of two wraps correctly.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_ext   = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      idx_ext = {1'b0, ptr_q} + (GW+1)'(i);
      if (idx_ext >= (GW+1)'(S_COUNT)) begin
        idx_ext = idx_ext - (GW+1)'(S_COUNT);
      end
      if (!win_found && s_udp.hdr_valid[idx_ext[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_ext[GW-1:0];
      end
    end
  end
`else
  // Walk from the top index down so that the lowest requesting index is the
  // last one written, and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_udp.hdr_valid[i]) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ip_q    <= '0;
      sport_q <= '0;
      dport_q <= '0;
      len_q   <= '0;
      csum_q  <= '0;
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ip_q    <= ip_d;
      sport_q <= sport_d;
      dport_q <= dport_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ip_d        = ip_q;
    sport_d     = sport_q;
    dport_d     = dport_q;
    len_d       = len_q;
    csum_d      = csum_q;
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    hdr_ready_s = '0;
    tready_s    = '0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    beat_last   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          // hdr_ready is combinational here and is held low while reset is
          // asserted, so no requester ever sees an accept during reset.
          hdr_ready_s[win_idx] = !rst;
          grant_d = win_idx;
          ip_d    = s_udp.ip_dest_ip[win_idx*32 +: 32];
          sport_d = s_udp.source_port[win_idx*16 +: 16];
          dport_d = s_udp.dest_port[win_idx*16 +: 16];
          len_d   = s_udp.length[win_idx*16 +: 16];
          csum_d  = s_udp.checksum[win_idx*16 +: 16];
          state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        if (m_udp.hdr_ready) begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        m_tdata           = s_udp.tdata[grant_q*8 +: 8];
        m_tvalid          = s_udp.tvalid[grant_q];
        m_tlast           = s_udp.tlast[grant_q];
        m_tuser           = s_udp.tuser[grant_q];
        tready_s[grant_q] = m_udp.tready;
        beat_last         = m_tvalid && m_udp.tready && m_tlast;
        if (beat_last) begin
          state_d = ST_IDLE;
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
          ptr_d = (grant_q == GW'(S_COUNT - 1)) ? '0 : grant_q + 1'b1;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_udp.hdr_ready   = hdr_ready_s;
  assign s_udp.tready      = tready_s;

  assign m_udp.hdr_valid   = (state_q == ST_HDR);
  assign m_udp.ip_dest_ip  = ip_q;
  assign m_udp.source_port = sport_q;
  assign m_udp.dest_port   = dport_q;
  assign m_udp.length      = len_q;
  assign m_udp.checksum    = csum_q;
  assign m_udp.tdata       = m_tdata;
  assign m_udp.tvalid      = m_tvalid;
  assign m_udp.tlast       = m_tlast;
  assign m_udp.tuser       = m_tuser;

  assign grant       = grant_q;
  assign grant_valid = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_arb
// Bench for udp_tx_arb with S_COUNT = 4. Lane drivers push the expected
// header and payload beats into queues at the moment their header is
// accepted. An independent monitor pops those queues on every output
// handshake and compares. The expected grant order depends on whether
// UDP_TX_ARB_ROUND_ROBIN_EN is defined.
// -----------------------------------------------------------------------------
module tb_udp_tx_arb;
  localparam int S_COUNT = 4;
  localparam int GW      = 2;
  localparam int HW      = GW + 32 + 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [GW-1:0] grant;
  logic          grant_valid;
  logic          busy;
  logic [1:0]    state_o;

  udp_tx_arb_if #(.N(S_COUNT)) s_if();
  udp_tx_arb_if #(.N(1))       m_if();

  udp_tx_arb #(.S_COUNT(S_COUNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_udp       (s_if.slave),
    .m_udp       (m_if.master),
    .grant       (grant),
    .grant_valid (grant_valid),
    .busy        (busy),
    .state_o     (state_o)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int               errors = 0;
  int               checks = 0;
  logic [HW-1:0]    exp_hdr_q[$];
  logic [9:0]       exp_beat_q[$];
  logic [GW-1:0]    grant_seen[$];
  logic [HW-1:0]    mon_hdr;
  logic [9:0]       mon_beat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.hdr_valid && m_if.hdr_ready) begin
        grant_seen.push_back(grant);
        if (exp_hdr_q.size() == 0) begin
          check("hdr_unexpected", 128'(exp_hdr_q.size()), 128'd1);
        end else begin
          mon_hdr = exp_hdr_q.pop_front();
          check("hdr", {grant, m_if.ip_dest_ip, m_if.source_port, m_if.dest_port,
                        m_if.length, m_if.checksum}, mon_hdr);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_beat_q.size() == 0) begin
          check("beat_unexpected", 128'(exp_beat_q.size()), 128'd1);
        end else begin
          mon_beat = exp_beat_q.pop_front();
          check("beat", {m_if.tuser, m_if.tlast, m_if.tdata}, mon_beat);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic set_hdr(input int lane, input logic [31:0] ip, input logic [15:0] sp,
                         input logic [15:0] dp, input logic [15:0] len, input logic [15:0] cs);
    s_if.ip_dest_ip[lane*32 +: 32]  = ip;
    s_if.source_port[lane*16 +: 16] = sp;
    s_if.dest_port[lane*16 +: 16]   = dp;
    s_if.length[lane*16 +: 16]      = len;
    s_if.checksum[lane*16 +: 16]    = cs;
  endtask

  // Called just after a rising edge. Byte k of the frame is data[8k +: 8];
  // umask[k] is that byte's tuser.
  task automatic drive_frame(input int lane, input logic [31:0] ip, input logic [15:0] sp,
                             input logic [15:0] dp, input logic [15:0] len,
                             input logic [15:0] cs, input logic [63:0] data,
                             input int n, input logic [7:0] umask);
    int cnt;
    set_hdr(lane, ip, sp, dp, len, cs);
    s_if.hdr_valid[lane] = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!s_if.hdr_ready[lane] && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (!s_if.hdr_ready[lane]) begin
      check("hdr_ready_timeout", 128'(s_if.hdr_ready[lane]), 128'd1);
      s_if.hdr_valid[lane] = 1'b0;
      return;
    end
    exp_hdr_q.push_back({GW'(lane), ip, sp, dp, len, cs});
    for (int k = 0; k < n; k++) begin
      exp_beat_q.push_back({umask[k], (k == n - 1), data[8*k +: 8]});
    end
    @(posedge clk); #1;
    s_if.hdr_valid[lane] = 1'b0;
    for (int k = 0; k < n; k++) begin
      s_if.tdata[lane*8 +: 8] = data[8*k +: 8];
      s_if.tvalid[lane]       = 1'b1;
      s_if.tlast[lane]        = (k == n - 1);
      s_if.tuser[lane]        = umask[k];
      cnt = 0;
      @(negedge clk);
      while (!s_if.tready[lane] && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      if (!s_if.tready[lane]) begin
        check("tready_timeout", 128'(s_if.tready[lane]), 128'd1);
        s_if.tvalid[lane] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid[lane] = 1'b0;
    s_if.tlast[lane]  = 1'b0;
    s_if.tuser[lane]  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  int   wcnt;
  logic [GW-1:0] exp_order[6];

  initial begin
`ifdef UDP_TX_ARB_ROUND_ROBIN_EN
    exp_order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
`else
    exp_order = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
`endif
    rst              = 1'b1;
    s_if.hdr_valid   = '0;
    s_if.ip_dest_ip  = '0;
    s_if.source_port = '0;
    s_if.dest_port   = '0;
    s_if.length      = '0;
    s_if.checksum    = '0;
    s_if.tdata       = '0;
    s_if.tvalid      = '0;
    s_if.tlast       = '0;
    s_if.tuser       = '0;
    m_if.hdr_ready   = 1'b1;
    m_if.tready      = 1'b1;

    // Reset values, with a request already pending on lane 0.
    set_hdr(0, 32'h01020304, 16'd1, 16'd2, 16'd3, 16'd4);
    s_if.hdr_valid[0] = 1'b1;
    #3;
    check("rst_m_hdr_valid", 128'(m_if.hdr_valid), 128'd0);
    check("rst_m_ip", 128'(m_if.ip_dest_ip), 128'd0);
    check("rst_m_len", 128'(m_if.length), 128'd0);
    check("rst_grant", 128'(grant), 128'd0);
    check("rst_grant_valid", 128'(grant_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_s_hdr_ready", 128'(s_if.hdr_ready), 128'd0);
    check("rst_s_tready", 128'(s_if.tready), 128'd0);
    check("rst_m_tvalid", 128'(m_if.tvalid), 128'd0);
    s_if.hdr_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame on lane 0, header latency and busy.
    @(posedge clk); #1;
    fork
      drive_frame(0, 32'h0A000001, 16'd1234, 16'd5678, 16'd12, 16'h1111,
                  64'h00000000DDCCBBAA, 4, 8'h00);
      begin
        @(negedge clk);
        check("t1_hdr_ready_pulse", 128'(s_if.hdr_ready), 128'h1);
        check("t1_m_hdr_valid_n", 128'(m_if.hdr_valid), 128'd0);
        @(negedge clk);
        check("t1_m_hdr_valid_n1", 128'(m_if.hdr_valid), 128'd1);
        check("t1_hdr_ready_gone", 128'(s_if.hdr_ready), 128'h0);
        check("t1_grant_valid", 128'(grant_valid), 128'd1);
        check("t1_busy", 128'(busy), 128'd1);
      end
    join
    @(negedge clk);
    check("t1_busy_after", 128'(busy), 128'd0);
    check("t1_grant_valid_after", 128'(grant_valid), 128'd0);

    // Output header stall for 5 cycles.
    @(posedge clk); #1;
    m_if.hdr_ready = 1'b0;
    fork
      drive_frame(0, 32'hC0A80102, 16'd100, 16'd200, 16'd10, 16'h2222,
                  64'h0000000000002211, 2, 8'h00);
      begin
        wcnt = 0;
        @(negedge clk);
        while (!m_if.hdr_valid && wcnt < 20) begin
          @(negedge clk);
          wcnt++;
        end
        check("t2_hdr_valid_seen", 128'(m_if.hdr_valid), 128'd1);
        for (int k = 0; k < 5; k++) begin
          check("t2_hdr_valid_hold", 128'(m_if.hdr_valid), 128'd1);
          check("t2_hdr_stable", {m_if.ip_dest_ip, m_if.source_port, m_if.dest_port,
                                  m_if.length, m_if.checksum},
                {32'hC0A80102, 16'd100, 16'd200, 16'd10, 16'h2222});
          check("t2_no_tready", 128'(s_if.tready), 128'd0);
          check("t2_no_tvalid", 128'(m_if.tvalid), 128'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        m_if.hdr_ready = 1'b1;
      end
    join

    // Lanes 0, 1 and 3 competing with two 2-byte frames each.
    do_reset();
    grant_seen.delete();
    fork
      begin
        drive_frame(0, 32'h00000A00, 16'd10, 16'd11, 16'd2, 16'h0A00, 64'h0A01, 2, 8'h00);
        drive_frame(0, 32'h00000A01, 16'd12, 16'd13, 16'd2, 16'h0A01, 64'h0A03, 2, 8'h00);
      end
      begin
        drive_frame(1, 32'h00000B00, 16'd20, 16'd21, 16'd2, 16'h0B00, 64'h0B01, 2, 8'h00);
        drive_frame(1, 32'h00000B01, 16'd22, 16'd23, 16'd2, 16'h0B01, 64'h0B03, 2, 8'h00);
      end
      begin
        drive_frame(3, 32'h00000D00, 16'd30, 16'd31, 16'd2, 16'h0D00, 64'h0D01, 2, 8'h00);
        drive_frame(3, 32'h00000D01, 16'd32, 16'd33, 16'd2, 16'h0D01, 64'h0D03, 2, 8'h00);
      end
    join
    check("t3_grant_count", 128'(grant_seen.size()), 128'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_seen.size()) begin
        check("t3_grant_order", 128'(grant_seen[k]), 128'(exp_order[k]));
      end
    end

    // Payload backpressure on lane 2 with a tuser beat.
    @(posedge clk); #1;
    fork
      drive_frame(2, 32'h0000C200, 16'd40, 16'd41, 16'd4, 16'h0C20,
                  64'h000000002D2C2B2A, 4, 8'h02);
      begin
        wcnt = 0;
        @(negedge clk);
        while (!(m_if.hdr_valid && m_if.hdr_ready) && wcnt < 20) begin
          @(negedge clk);
          wcnt++;
        end
        check("t4_hdr_seen", 128'(m_if.hdr_valid), 128'd1);
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          m_if.tready = ((k % 2) == 0);
          @(negedge clk);
          check("t4_tready_mirror", 128'(s_if.tready), ((k % 2) == 0) ? 128'h4 : 128'h0);
          if (k == 0) check("t4_grant", 128'(grant), 128'd2);
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
      end
    join

    // Asynchronous reset in the middle of a 6-byte frame on lane 1.
    @(posedge clk); #1;
    set_hdr(1, 32'h0000E100, 16'd50, 16'd51, 16'd6, 16'h0E10);
    s_if.hdr_valid[1] = 1'b1;
    wcnt = 0;
    @(negedge clk);
    while (!s_if.hdr_ready[1] && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    check("t5_lane1_accept", 128'(s_if.hdr_ready[1]), 128'd1);
    exp_hdr_q.push_back({2'd1, 32'h0000E100, 16'd50, 16'd51, 16'd6, 16'h0E10});
    exp_beat_q.push_back({1'b0, 1'b0, 8'h61});
    exp_beat_q.push_back({1'b0, 1'b0, 8'h62});
    @(posedge clk); #1;
    s_if.hdr_valid[1] = 1'b0;
    set_hdr(0, 32'h0000F000, 16'd60, 16'd61, 16'd1, 16'h0F00);
    s_if.hdr_valid[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      s_if.tdata[15:8] = 8'h61 + 8'(b);
      s_if.tvalid[1]   = 1'b1;
      s_if.tlast[1]    = 1'b0;
      wcnt = 0;
      @(negedge clk);
      while (!s_if.tready[1] && wcnt < 20) begin
        @(negedge clk);
        wcnt++;
      end
      check("t5_beat_ready", 128'(s_if.tready[1]), 128'd1);
      @(posedge clk); #1;
    end
    s_if.tdata[15:8] = 8'h63;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_m_tvalid", 128'(m_if.tvalid), 128'd0);
    check("t5_rst_m_hdr_valid", 128'(m_if.hdr_valid), 128'd0);
    check("t5_rst_busy", 128'(busy), 128'd0);
    check("t5_rst_grant_valid", 128'(grant_valid), 128'd0);
    check("t5_rst_grant", 128'(grant), 128'd0);
    check("t5_rst_s_tready", 128'(s_if.tready), 128'd0);
    check("t5_rst_s_hdr_ready", 128'(s_if.hdr_ready), 128'd0);
    check("t5_rst_m_ip", 128'(m_if.ip_dest_ip), 128'd0);
    check("t5_rst_state", 128'(state_o), 128'd0);
    s_if.tvalid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      drive_frame(0, 32'h0000F000, 16'd60, 16'd61, 16'd1, 16'h0F00,
                  64'h00000000000000F1, 1, 8'h00);
      begin
        @(negedge clk);
        check("t5_lane0_granted", 128'(s_if.hdr_ready), 128'h1);
      end
    join

    repeat (3) @(negedge clk);
    check("end_hdr_q_empty", 128'(exp_hdr_q.size()), 128'd0);
    check("end_beat_q_empty", 128'(exp_beat_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
